// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one single-port synchronous SRAM between the instruction-fetch requester
// (read-only) and the data requester (read/write). At most one SRAM access is
// issued per cycle. Data has priority, but a saturating starvation counter forces
// a fetch grant after STARVE_LIMIT consecutive data grants while fetch waits.
// A LATENCY-deep tag pipeline remembers who owns each access so the response
// arriving LATENCY cycles later on sram_rdata is steered back to its owner.
// inst_cancel drops every in-flight fetch response. Data responses are never
// affected by it.

module sram_port_arbiter #(
    parameter int LATENCY      = 1,  // SRAM read latency, 1..4
    parameter int STARVE_LIMIT = 4   // data grants tolerated while fetch waits, 1..15
) (
    input  logic        clk,
    input  logic        reset,

    // fetch requester
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic        inst_cancel,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    // data requester
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    // unified SRAM port
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    // ------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------
    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    localparam int               CNT_W      = 4;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] starve_cnt;
    tag_t             tag_pipe [LATENCY];
    logic [31:0]      inst_rdata_q;
    logic [31:0]      data_rdata_q;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic inst_grant;
    logic data_grant;
    logic starved;
    tag_t tag_in;
    tag_t tag_out;

    // A fetch tag loses its valid bit when the fetch stream is cancelled.
    // Data tags pass through untouched.
    function automatic tag_t apply_cancel(input tag_t t, input logic cancel);
        tag_t r;
        r       = t;
        r.valid = t.valid && !(cancel && (t.owner == OWN_INST));
        return r;
    endfunction

    assign starved = (starve_cnt == STARVE_MAX);

    // Grant: data wins unless fetch has been starved to the limit; nothing is granted in reset.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        inst_grant = 1'b0;
        data_grant = 1'b0;
        if (!reset) begin
            if (inst_req && (!data_req || starved)) begin
                inst_grant = 1'b1;
            end else if (data_req) begin
                data_grant = 1'b1;
            end
        end
    end

    assign inst_addr_ok = inst_grant;
    assign data_addr_ok = data_grant;

    // SRAM drive: the winner's address, and write enables only for a data write.
    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (inst_grant) begin
            sram_en   = 1'b1;
            sram_addr = inst_addr;
        end else if (data_grant) begin
            sram_en   = 1'b1;
            sram_addr = data_addr;
            if (data_wr) begin
                sram_wen   = data_wstrb;
                sram_wdata = data_wdata;
            end
        end
    end

    // Starvation counter: counts data grants that overtook a waiting fetch, saturating at the limit.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples the pre-edge values regardless of block order.
        if (reset) begin
            starve_cnt <= '0;
        end else if (inst_grant || !inst_req) begin
            starve_cnt <= '0;
        end else if (data_grant && !starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Tag entering the pipeline this cycle.
    // A fetch granted together with inst_cancel enters already invalid.
    always_comb begin
        tag_in.valid = data_grant || (inst_grant && !inst_cancel);
        tag_in.owner = data_grant ? OWN_DATA : OWN_INST;
    end

    // Tag pipeline: shifts one stage per cycle in lock step with the SRAM read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: this small array is reset on purpose. Its valid bits decide
            // whether a response is signalled, so stale tags must never survive
            // reset. Wide data storage would normally be left unreset.
            for (int i = 0; i < LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < LATENCY; i++) begin
                tag_pipe[i] <= apply_cancel(tag_pipe[i-1], inst_cancel);
            end
        end
    end

    assign tag_out = tag_pipe[LATENCY-1];

    // Response strobes: the last stage names the owner of the data now on sram_rdata.
    always_comb begin
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        if (!reset && tag_out.valid) begin
            inst_data_ok = (tag_out.owner == OWN_INST);
            data_data_ok = (tag_out.owner == OWN_DATA);
        end
    end

    // Read-data hold registers: each requester keeps its last response while the other is served.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            if (inst_data_ok) begin
                inst_rdata_q <= sram_rdata;
            end
            if (data_data_ok) begin
                data_rdata_q <= sram_rdata;
            end
        end
    end

    // Read-data outputs: live SRAM data in the response cycle, otherwise the held value.
    always_comb begin
        inst_rdata = inst_rdata_q;
        data_rdata = data_rdata_q;
        if (reset) begin
            inst_rdata = '0;
            data_rdata = '0;
        end else begin
            if (inst_data_ok) begin
                inst_rdata = sram_rdata;
            end
            if (data_data_ok) begin
                data_rdata = sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
// Directed bench for sram_port_arbiter with two instances on shared inputs.
// dut1 uses LATENCY=1 and dut3 uses LATENCY=3.
// Each step drives the inputs and states which requester must win this cycle.
// Every grant pushes an expected response onto a queue.
// The queue is popped when the response cycle comes round.
// sram_rdata is a per-cycle pattern chosen by the bench, so the expected read
// data is always known here.

module tb_sram_port_arbiter;

    typedef enum int {G_NONE, G_INST, G_DATA} grant_e;

    typedef struct {
        int due;
        bit is_inst;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_cancel;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] sram_rdata;

    // LATENCY = 1 instance
    logic        inst_addr_ok1, inst_data_ok1, data_addr_ok1, data_data_ok1, sram_en1;
    logic [31:0] inst_rdata1, data_rdata1, sram_addr1, sram_wdata1;
    logic [3:0]  sram_wen1;

    // LATENCY = 3 instance
    logic        inst_addr_ok3, inst_data_ok3, data_addr_ok3, data_data_ok3, sram_en3;
    logic [31:0] inst_rdata3, data_rdata3, sram_addr3, sram_wdata3;
    logic [3:0]  sram_wen3;

    int          n_vec  = 0;
    int          n_miss = 0;
    int          cyc_no = 0;
    logic [31:0] rd_val;
    logic [31:0] last_inst;
    logic [31:0] last_data;
    exp_t        sb[$];

    sram_port_arbiter #(.LATENCY(1), .STARVE_LIMIT(4)) dut1 (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
        .inst_addr_ok(inst_addr_ok1), .inst_data_ok(inst_data_ok1), .inst_rdata(inst_rdata1),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok1), .data_data_ok(data_data_ok1), .data_rdata(data_rdata1),
        .sram_en(sram_en1), .sram_wen(sram_wen1), .sram_addr(sram_addr1),
        .sram_wdata(sram_wdata1), .sram_rdata(sram_rdata)
    );

    sram_port_arbiter #(.LATENCY(3), .STARVE_LIMIT(4)) dut3 (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
        .inst_addr_ok(inst_addr_ok3), .inst_data_ok(inst_data_ok3), .inst_rdata(inst_rdata3),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok3), .data_data_ok(data_data_ok3), .data_rdata(data_rdata3),
        .sram_en(sram_en3), .sram_wen(sram_wen3), .sram_addr(sram_addr3),
        .sram_wdata(sram_wdata3), .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_miss++;
            $error("FAIL %s (cycle %0d): observed 0x%08h expected 0x%08h", tag, cyc_no, obs, want);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic want);
        check(tag, {31'b0, obs}, {31'b0, want});
    endtask

    // Request-side checks for one instance; the grant decision does not depend on latency.
    task automatic check_port(input string who, input grant_e g,
                              input logic iao, input logic dao, input logic en,
                              input logic [3:0] wen, input logic [31:0] addr,
                              input logic [31:0] wdata);
        check_bit({who, ".inst_addr_ok"}, iao, g == G_INST);
        check_bit({who, ".data_addr_ok"}, dao, g == G_DATA);
        check_bit({who, ".sram_en"}, en, g != G_NONE);
        case (g)
            G_INST: begin
                check({who, ".sram_wen"}, {28'b0, wen}, 32'h0);
                check({who, ".sram_addr"}, addr, inst_addr);
            end
            G_DATA: begin
                check({who, ".sram_wen"}, {28'b0, wen}, data_wr ? {28'b0, data_wstrb} : 32'h0);
                check({who, ".sram_addr"}, addr, data_addr);
                if (data_wr) check({who, ".sram_wdata"}, wdata, data_wdata);
            end
            default: begin
                check({who, ".sram_wen"}, {28'b0, wen}, 32'h0);
                if (reset) begin
                    check({who, ".sram_addr(rst)"}, addr, 32'h0);
                    check({who, ".sram_wdata(rst)"}, wdata, 32'h0);
                end
            end
        endcase
    endtask

    // One clock cycle. The inputs are already driven on entry.
    // chk3 also checks the response side of the LATENCY=3 instance against exp3 = {inst_ok, data_ok}.
    task automatic cyc(input grant_e g, input bit chk3 = 1'b0, input logic [1:0] exp3 = 2'b00);
        exp_t head;
        logic want_i;
        logic want_d;
        rd_val     = {cyc_no[15:0] ^ 16'ha5c3, ~cyc_no[15:0]};
        sram_rdata = rd_val;
        if (reset) begin
            sb.delete();
            last_inst = '0;
            last_data = '0;
        end
        #4;
        check_port("dut1", g, inst_addr_ok1, data_addr_ok1, sram_en1, sram_wen1, sram_addr1, sram_wdata1);
        check_port("dut3", g, inst_addr_ok3, data_addr_ok3, sram_en3, sram_wen3, sram_addr3, sram_wdata3);

        want_i = 1'b0;
        want_d = 1'b0;
        if (sb.size() > 0 && sb[0].due == cyc_no) begin
            head = sb.pop_front();
            if (head.is_inst) want_i = 1'b1;
            else              want_d = 1'b1;
        end
        if (want_i) last_inst = rd_val;
        if (want_d) last_data = rd_val;
        check_bit("dut1.inst_data_ok", inst_data_ok1, want_i);
        check_bit("dut1.data_data_ok", data_data_ok1, want_d);
        check("dut1.inst_rdata", inst_rdata1, last_inst);
        check("dut1.data_rdata", data_rdata1, last_data);

        if (chk3) begin
            check_bit("dut3.inst_data_ok", inst_data_ok3, exp3[1]);
            check_bit("dut3.data_data_ok", data_data_ok3, exp3[0]);
            if (exp3[1]) check("dut3.inst_rdata", inst_rdata3, rd_val);
            if (exp3[0]) check("dut3.data_rdata", data_rdata3, rd_val);
        end

        if (g == G_INST && !inst_cancel) sb.push_back('{due: cyc_no + 1, is_inst: 1'b1});
        if (g == G_DATA)                 sb.push_back('{due: cyc_no + 1, is_inst: 1'b0});

        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic idle_inputs();
        inst_req    = 1'b0;
        inst_cancel = 1'b0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_wstrb  = 4'h0;
    endtask

    initial begin
        reset       = 1'b1;
        inst_addr   = 32'h0;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        sram_rdata  = 32'h0;
        last_inst   = 32'h0;
        last_data   = 32'h0;
        idle_inputs();
        @(posedge clk);
        #1;

        // Reset: everything must read zero.
        cyc(G_NONE, 1'b1, 2'b00);
        cyc(G_NONE, 1'b1, 2'b00);
        reset = 1'b0;
        cyc(G_NONE, 1'b1, 2'b00);

        // Single fetch from the boot vector.
        inst_req = 1'b1; inst_addr = 32'hbfc0_0000;
        cyc(G_INST);
        idle_inputs();
        cyc(G_NONE);

        // Fetch and data read together: data first, then fetch.
        inst_req = 1'b1; inst_addr = 32'hbfc0_0004;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0100;
        cyc(G_DATA);
        data_req = 1'b0;
        cyc(G_INST);
        idle_inputs();
        cyc(G_NONE);

        // Starvation: four data grants, then a forced fetch, then data again.
        inst_req = 1'b1;
        data_req = 1'b1; data_wr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            inst_addr = 32'h8000_0000 + 32'(4 * i);
            data_addr = 32'h0000_0180 + 32'(4 * i);
            cyc((i == 4) ? G_INST : G_DATA);
        end
        data_req = 1'b0;
        cyc(G_INST);
        idle_inputs();
        cyc(G_NONE);

        // Partial write, then a write with no strobes that must still be acked.
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
        data_addr = 32'h0000_0200; data_wdata = 32'h1234_abcd;
        cyc(G_DATA);
        data_wstrb = 4'b0000; data_addr = 32'h0000_0204; data_wdata = 32'hdead_beef;
        cyc(G_DATA);
        idle_inputs();
        cyc(G_NONE);

        // Back-to-back traffic alternating owners. Each hold register keeps its last value.
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b1111;
        data_addr = 32'h0000_0300; data_wdata = 32'h0bad_cafe;
        cyc(G_DATA);
        data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h0000_1000;
        cyc(G_INST);
        inst_req = 1'b0; data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0304;
        cyc(G_DATA);
        data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h0000_1004;
        cyc(G_INST);
        idle_inputs();
        cyc(G_NONE);

        // A fetch granted in the same cycle as inst_cancel never responds.
        inst_req = 1'b1; inst_cancel = 1'b1; inst_addr = 32'h0000_2000;
        cyc(G_INST);
        idle_inputs();
        cyc(G_NONE);
        cyc(G_NONE);

        // LATENCY=3: a plain fetch returns three cycles after its grant.
        inst_req = 1'b1; inst_addr = 32'h0000_3000;
        cyc(G_INST, 1'b1, 2'b00);
        idle_inputs();
        cyc(G_NONE, 1'b1, 2'b00);
        cyc(G_NONE, 1'b1, 2'b00);
        cyc(G_NONE, 1'b1, 2'b10);
        cyc(G_NONE, 1'b1, 2'b00);

        // LATENCY=3: fetch, data read, cancel. The fetch is dropped and the data still returns.
        inst_req = 1'b1; inst_addr = 32'h0000_3100;
        cyc(G_INST, 1'b1, 2'b00);
        inst_req = 1'b0; data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_3104;
        cyc(G_DATA, 1'b1, 2'b00);
        data_req = 1'b0; inst_cancel = 1'b1;
        cyc(G_NONE, 1'b1, 2'b00);
        inst_cancel = 1'b0;
        cyc(G_NONE, 1'b1, 2'b00);
        cyc(G_NONE, 1'b1, 2'b01);
        cyc(G_NONE, 1'b1, 2'b00);

        // Reset right after an accepted fetch.
        // Requests are held during reset and must not be granted.
        inst_req = 1'b1; inst_addr = 32'h0000_4000;
        cyc(G_INST, 1'b1, 2'b00);
        reset = 1'b1;
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hf;
        data_addr = 32'h0000_4004; data_wdata = 32'h5555_aaaa;
        cyc(G_NONE, 1'b1, 2'b00);
        cyc(G_NONE, 1'b1, 2'b00);
        reset = 1'b0;
        idle_inputs();
        cyc(G_NONE, 1'b1, 2'b00);
        cyc(G_NONE, 1'b1, 2'b00);
        cyc(G_NONE, 1'b1, 2'b00);
        cyc(G_NONE, 1'b1, 2'b00);

        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
